// File: rtl/matmul_arbiter.sv
// matmul_arbiter: two-requester round-robin scheduler for the shared 2x2 matmul datapath.
//
// Accepts a full operand set from one of two requesters, holds the operands on mm_a/mm_b for
// SETTLE cycles, captures the combinational product from mm_c and returns it, tagged with the
// requester id, over a valid/ready response channel.
//
// Ports:
//   clk                  rising-edge clock
//   nRST                 synchronous active-low reset
//   req0_valid/ops/ready requester 0 handshake, ops = {A00,A01,A10,A11,B00,B01,B10,B11}
//   req1_valid/ops/ready requester 1 handshake, same layout
//   mm_a, mm_b           registered operands driven to the multiplier
//   mm_c                 product {C00,C01,C10,C11} from the multiplier
//   rsp_valid/id/c/ready response handshake
//   busy                 high whenever a job is in flight (state is not idle)
module matmul_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        req0_valid,
    input  logic [31:0] req0_ops,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_ops,
    output logic        req1_ready,
    output logic [15:0] mm_a,
    output logic [15:0] mm_b,
    input  logic [31:0] mm_c,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_c,
    input  logic        rsp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mm_a_q, mm_a_d;
    logic [15:0] mm_b_q, mm_b_d;
    logic [31:0] rsp_c_q, rsp_c_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        grant;
    logic        grant_vld;
    logic        accept;
    logic [31:0] grant_ops;

    // Grant: a lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant     = 1'b0;
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        grant_ops = grant ? req1_ops : req0_ops;
    end

    // Ready is forced low while reset is asserted so nothing looks accepted on a reset edge.
    assign req0_ready = nRST && (state_q == StIdle) && grant_vld && !grant;
    assign req1_ready = nRST && (state_q == StIdle) && grant_vld && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        state_d      = state_q;
        mm_a_d       = mm_a_q;
        mm_b_d       = mm_b_q;
        rsp_c_d      = rsp_c_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    mm_a_d       = grant_ops[31:16];
                    mm_b_d       = grant_ops[15:0];
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = 3'(SETTLE);
                    state_d      = StRun;
                end
            end
            StRun: begin
                // cnt reaching 1 marks the last settle cycle; mm_c is sampled on this edge.
                if (cnt_q == 3'd1) begin
                    rsp_c_d     = mm_c;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q      <= StIdle;
            mm_a_q       <= 16'h0;
            mm_b_q       <= 16'h0;
            rsp_c_q      <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            mm_a_q       <= mm_a_d;
            mm_b_q       <= mm_b_d;
            rsp_c_q      <= rsp_c_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_matmul_arbiter.sv
// Testbench for matmul_arbiter: a cycle table on a SETTLE=1 instance plus a hand-written
// latency sequence on a SETTLE=4 instance whose product model lags the operands.
module tb_matmul_arbiter;

    localparam logic [31:0] P  = 32'h12345678;
    localparam logic [31:0] Q  = 32'hFFFFFFFF;
    localparam logic [31:0] PC = 32'h13162B32;
    localparam logic [31:0] QC = 32'hC2C2C2C2;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [15:0] A  = 16'h1234;
    localparam logic [15:0] B  = 16'h5678;
    localparam logic [15:0] F  = 16'hFFFF;
    localparam logic [15:0] N  = 16'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 2x2 product, each element truncated to 8 bits.
    function automatic logic [31:0] mm(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11;
        logic [7:0] c00, c01, c10, c11;
        a00 = {4'h0, a[15:12]}; a01 = {4'h0, a[11:8]}; a10 = {4'h0, a[7:4]}; a11 = {4'h0, a[3:0]};
        b00 = {4'h0, b[15:12]}; b01 = {4'h0, b[11:8]}; b10 = {4'h0, b[7:4]}; b11 = {4'h0, b[3:0]};
        c00 = 8'(a00 * b00 + a01 * b10);
        c01 = 8'(a00 * b01 + a01 * b11);
        c10 = 8'(a10 * b00 + a11 * b10);
        c11 = 8'(a10 * b01 + a11 * b11);
        return {c00, c01, c10, c11};
    endfunction

    // Instance 1: SETTLE=1, combinational product.
    logic        nrst, v0, v1, rdy0, rdy1, rv, rid, rr, bz;
    logic [31:0] ops0, ops1, rc, mc;
    logic [15:0] ma, mb;
    assign mc = mm(ma, mb);

    matmul_arbiter #(.SETTLE(1)) u_dut (
        .clk       (clk),
        .nRST      (nrst),
        .req0_valid(v0),
        .req0_ops  (ops0),
        .req0_ready(rdy0),
        .req1_valid(v1),
        .req1_ops  (ops1),
        .req1_ready(rdy1),
        .mm_a      (ma),
        .mm_b      (mb),
        .mm_c      (mc),
        .rsp_valid (rv),
        .rsp_id    (rid),
        .rsp_c     (rc),
        .rsp_ready (rr),
        .busy      (bz)
    );

    // Instance 2: SETTLE=4, product appears 3 edges after the operands change.
    logic        d2_nrst, d2_v0, d2_rdy0, d2_rdy1, d2_rv, d2_rid, d2_bz;
    logic [31:0] d2_ops0, d2_rc, d2_mc, p1, p2;
    logic [15:0] d2_ma, d2_mb;

    always @(posedge clk) begin
        p1    <= mm(d2_ma, d2_mb);
        p2    <= p1;
        d2_mc <= p2;
    end

    matmul_arbiter #(.SETTLE(4)) u_dut4 (
        .clk       (clk),
        .nRST      (d2_nrst),
        .req0_valid(d2_v0),
        .req0_ops  (d2_ops0),
        .req0_ready(d2_rdy0),
        .req1_valid(1'b0),
        .req1_ops  (32'h0),
        .req1_ready(d2_rdy1),
        .mm_a      (d2_ma),
        .mm_b      (d2_mb),
        .mm_c      (d2_mc),
        .rsp_valid (d2_rv),
        .rsp_id    (d2_rid),
        .rsp_c     (d2_rc),
        .rsp_ready (1'b1),
        .busy      (d2_bz)
    );

    typedef struct {
        logic        nrst, v0;
        logic [31:0] ops0;
        logic        v1;
        logic [31:0] ops1;
        logic        rr;
        logic        erdy0, erdy1, ebusy, erv, erid;
        logic [31:0] erc;
        logic [15:0] ema, emb;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = 0;

    task automatic add(input logic n, input logic a0, input logic [31:0] o0, input logic a1,
                       input logic [31:0] o1, input logic r, input logic e0, input logic e1,
                       input logic eb, input logic ev, input logic ei, input logic [31:0] ec,
                       input logic [15:0] ea, input logic [15:0] eb2);
        vec_t t;
        t.nrst = n; t.v0 = a0; t.ops0 = o0; t.v1 = a1; t.ops1 = o1; t.rr = r;
        t.erdy0 = e0; t.erdy1 = e1; t.ebusy = eb; t.erv = ev; t.erid = ei;
        t.erc = ec; t.ema = ea; t.emb = eb2;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, cur, act, exp);
        end
    endtask

    initial begin
        int edges;
        logic [31:0] jobs[2];
        logic [31:0] exps[2];

        // nrst v0 ops0 v1 ops1 rr | rdy0 rdy1 | busy rv rid rc ma mb
        add(0, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, Z,  N, N);   // reset
        add(1, 1, P, 0, Z, 1, 1, 0, 1, 0, 0, Z,  A, B);   // single job accept
        add(1, 0, Z, 0, Z, 1, 0, 0, 1, 1, 0, PC, A, B);
        add(1, 0, Z, 0, Z, 1, 0, 0, 0, 0, 0, PC, A, B);
        add(0, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, Z,  N, N);   // reset, then ties
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, Z,  A, B);
        add(1, 1, P, 1, Q, 1, 0, 0, 1, 1, 0, PC, A, B);
        add(1, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, PC, A, B);
        add(1, 1, P, 1, Q, 1, 0, 1, 1, 0, 1, PC, F, F);
        add(1, 1, P, 1, Q, 1, 0, 0, 1, 1, 1, QC, F, F);
        add(1, 1, P, 1, Q, 1, 0, 0, 0, 0, 1, QC, F, F);
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, QC, A, B);
        add(1, 1, P, 1, Q, 1, 0, 0, 1, 1, 0, PC, A, B);
        add(1, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, PC, A, B);
        add(1, 1, P, 1, Q, 1, 0, 1, 1, 0, 1, PC, F, F);
        add(1, 1, P, 1, Q, 1, 0, 0, 1, 1, 1, QC, F, F);
        for (int i = 0; i < 5; i++) begin                 // response backpressure
            add(1, 1, P, 1, Q, 0, 0, 0, 1, 1, 1, QC, F, F);
        end
        add(1, 1, P, 1, Q, 1, 0, 0, 0, 0, 1, QC, F, F);
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, QC, A, B);
        add(0, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, Z,  N, N);   // reset during run
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, Z,  A, B);
        add(1, 1, P, 1, Q, 0, 0, 0, 1, 1, 0, PC, A, B);
        add(0, 1, P, 1, Q, 1, 0, 0, 0, 0, 0, Z,  N, N);   // reset during resp
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, Z,  A, B);
        add(1, 0, Z, 0, Z, 1, 0, 0, 1, 1, 0, PC, A, B);
        add(1, 0, Z, 0, Z, 1, 0, 0, 0, 0, 0, PC, A, B);
        for (int i = 0; i < 3; i++) begin                 // lone requester 1
            add(1, 0, Z, 1, Q, 1, 0, 1, 1, 0, 1, (i == 0) ? PC : QC, F, F);
            add(1, (i == 2) ? 1'b1 : 1'b0, P, 1, Q, 1, 0, 0, 1, 1, 1, QC, F, F);
            add(1, (i == 2) ? 1'b1 : 1'b0, P, 1, Q, 1, 0, 0, 0, 0, 1, QC, F, F);
        end
        add(1, 1, P, 1, Q, 1, 1, 0, 1, 0, 0, QC, A, B);   // tie after lone run
        add(1, 0, Z, 0, Z, 1, 0, 0, 1, 1, 0, PC, A, B);
        add(1, 0, Z, 0, Z, 1, 0, 0, 0, 0, 0, PC, A, B);
        add(1, 0, Z, 0, Z, 1, 0, 0, 0, 0, 0, PC, A, B);   // idle, spurious rsp_ready

        d2_nrst = 1'b0; d2_v0 = 1'b0; d2_ops0 = 32'h0;
        nrst = 1'b0; v0 = 1'b0; v1 = 1'b0; ops0 = 32'h0; ops1 = 32'h0; rr = 1'b0;

        foreach (vecs[k]) begin
            cur = k;
            @(negedge clk);
            nrst = vecs[k].nrst; v0 = vecs[k].v0; ops0 = vecs[k].ops0;
            v1 = vecs[k].v1; ops1 = vecs[k].ops1; rr = vecs[k].rr;
            #1;
            check("req0_ready", {31'h0, rdy0}, {31'h0, vecs[k].erdy0});
            check("req1_ready", {31'h0, rdy1}, {31'h0, vecs[k].erdy1});
            @(posedge clk);
            #1;
            check("busy", {31'h0, bz}, {31'h0, vecs[k].ebusy});
            check("rsp_valid", {31'h0, rv}, {31'h0, vecs[k].erv});
            check("rsp_id", {31'h0, rid}, {31'h0, vecs[k].erid});
            check("rsp_c", rc, vecs[k].erc);
            check("mm_a", {16'h0, ma}, {16'h0, vecs[k].ema});
            check("mm_b", {16'h0, mb}, {16'h0, vecs[k].emb});
        end

        // Settle sequence on the SETTLE=4 instance; second job checks against a stale product.
        jobs[0] = P; jobs[1] = Q;
        exps[0] = PC; exps[1] = QC;
        @(negedge clk);
        d2_nrst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            cur = 1000 + j;
            @(negedge clk);
            d2_v0 = 1'b1; d2_ops0 = jobs[j];
            #1;
            check("s4_req0_ready", {31'h0, d2_rdy0}, 32'h1);
            @(posedge clk);
            #1;
            check("s4_busy_rise", {31'h0, d2_bz}, 32'h1);
            check("s4_mm_a", {16'h0, d2_ma}, {16'h0, jobs[j][31:16]});
            @(negedge clk);
            d2_v0 = 1'b0;
            edges = 0;
            while (!d2_rv && edges < 10) begin
                @(posedge clk);
                #1;
                edges++;
            end
            check("s4_latency", 32'(edges), 32'd4);
            check("s4_rsp_c", d2_rc, exps[j]);
            check("s4_rsp_id", {31'h0, d2_rid}, 32'h0);
            @(posedge clk);
            #1;
            check("s4_busy_fall", {31'h0, d2_bz}, 32'h0);
            check("s4_rsp_valid_fall", {31'h0, d2_rv}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
